// File: rtl/demux_pkg.sv
// Shared definitions for the 1:N stream demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1, so that a 2-channel demux still has a select bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot: loads a beat, holds it until the consumer takes it.
module demux_out_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] beat_data,
  input  logic                  beat_last,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  valid
);

  // Load wins over drain so a pass-through consumer sees back-to-back beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= beat_data;
      last  <= beat_last;
      valid <= 1'b1;
    end else if (ready) begin
      last  <= 1'b0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1_n.sv
// 1:N packet demultiplexer: channel latched on the first beat, held until Last.
module stream_demux_1_n
  import demux_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_CHANNELS = 8,
  parameter  int COUNT_WIDTH  = 16,
  localparam int SEL_WIDTH    = clog2(NUM_CHANNELS)
) (
  input  logic                               Clock_In,
  input  logic                               Reset_N_In,
  input  logic                               Enable_In,
  input  logic [DATA_WIDTH-1:0]              Data_In,
  input  logic                               Valid_In,
  input  logic                               Last_In,
  input  logic [SEL_WIDTH-1:0]               Select_In,
  output logic                               Ready_Out,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_Out,
  output logic [NUM_CHANNELS-1:0]            Valid_Out,
  output logic [NUM_CHANNELS-1:0]            Last_Out,
  input  logic [NUM_CHANNELS-1:0]            Ready_In,
  output logic                               Busy_Out,
  output logic                               Error_Out,
  output logic [COUNT_WIDTH-1:0]             Drop_Count_Out
);

  state_t                  state, state_nxt;
  logic [SEL_WIDTH-1:0]    chan_q, chan_nxt;
  logic [NUM_CHANNELS-1:0] slot_free;
  logic [NUM_CHANNELS-1:0] load;
  logic                    sel_oob;
  logic                    free_sel;
  logic                    free_chan;
  logic                    start_drop;

  assign slot_free = ~Valid_Out | Ready_In;
  assign sel_oob   = 32'(Select_In) >= 32'(NUM_CHANNELS);
  assign Busy_Out  = (state != ST_IDLE);

  // Per-channel lookup avoids indexing past N when N is not a power of two.
  always_comb begin
    free_sel  = 1'b0;
    free_chan = 1'b0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (Select_In == SEL_WIDTH'(c)) free_sel  = slot_free[c];
      if (chan_q    == SEL_WIDTH'(c)) free_chan = slot_free[c];
    end
  end

  // Next-state, handshake and per-channel load decode.
  always_comb begin
    state_nxt  = state;
    chan_nxt   = chan_q;
    Ready_Out  = 1'b0;
    load       = '0;
    start_drop = 1'b0;
    unique case (state)
      ST_IDLE: begin
        Ready_Out = Enable_In & (sel_oob | free_sel);
        if (Valid_In && Ready_Out) begin
          if (sel_oob) begin
            start_drop = 1'b1;
            if (!Last_In) state_nxt = ST_DROP;
          end else begin
            chan_nxt = Select_In;
            load     = NUM_CHANNELS'(1) << Select_In;
            if (!Last_In) state_nxt = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        Ready_Out = free_chan;
        if (Valid_In && Ready_Out) begin
          load = NUM_CHANNELS'(1) << chan_q;
          if (Last_In) state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        Ready_Out = 1'b1;
        if (Valid_In && Last_In) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and latched channel.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state  <= ST_IDLE;
      chan_q <= '0;
    end else begin
      state  <= state_nxt;
      chan_q <= chan_nxt;
    end
  end

  // Error pulse and saturating count, one event per dropped packet.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      Error_Out      <= 1'b0;
      Drop_Count_Out <= '0;
    end else begin
      Error_Out <= start_drop;
      if (start_drop && (Drop_Count_Out != '1)) Drop_Count_Out <= Drop_Count_Out + 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_slot
    demux_out_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (Clock_In),
      .rst_n    (Reset_N_In),
      .load     (load[c]),
      .beat_data(Data_In),
      .beat_last(Last_In),
      .ready    (Ready_In[c]),
      .data     (Data_Out[c*DATA_WIDTH +: DATA_WIDTH]),
      .last     (Last_Out[c]),
      .valid    (Valid_Out[c])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Scoreboard bench: 8-channel instance for routing, 6-channel instance for drop paths.
module tb_stream_demux_1_n;

  logic        clk = 1'b0;
  logic        rst_n;
  // 8-channel instance
  logic        en, vin, lin, rdy, busy, err;
  logic [7:0]  din;
  logic [2:0]  sel;
  logic [63:0] dout;
  logic [7:0]  vout, lout, rin;
  logic [15:0] cnt;
  // 6-channel instance, narrow counter so saturation is reachable quickly
  logic        en6, vin6, lin6, rdy6, busy6, err6;
  logic [7:0]  din6;
  logic [2:0]  sel6;
  logic [47:0] dout6;
  logic [5:0]  vout6, lout6, rin6;
  logic [7:0]  cnt6;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb [8][$];

  always #5 clk = ~clk;

  stream_demux_1_n #(.DATA_WIDTH(8), .NUM_CHANNELS(8), .COUNT_WIDTH(16)) dut8 (
    .Clock_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Data_In(din), .Valid_In(vin),
    .Last_In(lin), .Select_In(sel), .Ready_Out(rdy), .Data_Out(dout), .Valid_Out(vout),
    .Last_Out(lout), .Ready_In(rin), .Busy_Out(busy), .Error_Out(err), .Drop_Count_Out(cnt)
  );

  stream_demux_1_n #(.DATA_WIDTH(8), .NUM_CHANNELS(6), .COUNT_WIDTH(8)) dut6 (
    .Clock_In(clk), .Reset_N_In(rst_n), .Enable_In(en6), .Data_In(din6), .Valid_In(vin6),
    .Last_In(lin6), .Select_In(sel6), .Ready_Out(rdy6), .Data_Out(dout6), .Valid_Out(vout6),
    .Last_Out(lout6), .Ready_In(rin6), .Busy_Out(busy6), .Error_Out(err6), .Drop_Count_Out(cnt6)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, record expected output channel.
  task automatic send(input logic [7:0] d, input logic l, input logic [2:0] s, input int ch);
    int budget;
    budget = 200;
    din = d; lin = l; sel = s; vin = 1'b1;
    do begin
      @(negedge clk);
      budget--;
    end while (!rdy && budget > 0);
    if (!rdy) begin
      chk($sformatf("accept_timeout_%0h", d), 64'(rdy), 64'd1);
    end else if (ch >= 0) begin
      sb[ch].push_back({l, d});
    end
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  // Monitor: every completed output handshake must match the head of that channel's queue.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int c = 0; c < 8; c++) begin
          if (vout[c] && rin[c]) begin
            if (sb[c].size() == 0) begin
              chk($sformatf("unexpected_beat_ch%0d", c), 64'(dout[c*8 +: 8]), 64'h1ff);
            end else begin
              e = sb[c].pop_front();
              chk($sformatf("ch%0d_data", c), 64'(dout[c*8 +: 8]), 64'(e[7:0]));
              chk($sformatf("ch%0d_last", c), 64'(lout[c]), 64'(e[8]));
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pending;
    rst_n = 1'b0; en = 1'b1; vin = 1'b0; lin = 1'b0; din = '0; sel = '0; rin = '1;
    en6 = 1'b1; vin6 = 1'b0; lin6 = 1'b0; din6 = '0; sel6 = '0; rin6 = '1;
    #1;
    chk("rst_vout", 64'(vout), 64'h0);
    chk("rst_lout", 64'(lout), 64'h0);
    chk("rst_dout", dout, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_cnt", 64'(cnt), 64'h0);
    chk("rst_cnt6", 64'(cnt6), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 64'(rdy), 64'h1);

    // 1: 3-beat packet to channel 5, pass-through ready
    send(8'hA1, 1'b0, 3'd5, 5);
    chk("t1_latency_vout", 64'(vout), 64'h20);
    chk("t1_busy", 64'(busy), 64'h1);
    send(8'hA2, 1'b0, 3'd5, 5);
    send(8'hA3, 1'b1, 3'd5, 5);
    chk("t1_idle_after_last", 64'(busy), 64'h0);

    // 2: Select changes mid-packet; next packet goes to the new channel
    send(8'hB1, 1'b0, 3'd5, 5);
    send(8'hB2, 1'b0, 3'd2, 5);
    send(8'hB3, 1'b1, 3'd2, 5);
    send(8'hC1, 1'b1, 3'd2, 2);
    chk("t2_err_none", 64'(err), 64'h0);

    // 3: backpressure on channel 3
    rin[3] = 1'b0;
    send(8'h31, 1'b0, 3'd3, 3);
    din = 8'h32; lin = 1'b1; sel = 3'd3; vin = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_ready", 64'(rdy), 64'h0);
      chk("t3_hold_valid", 64'(vout[3]), 64'h1);
      chk("t3_hold_data", 64'(dout[31:24]), 64'h31);
    end
    @(posedge clk); #1;
    rin[3] = 1'b1;
    send(8'h32, 1'b1, 3'd3, 3);

    // 5: Enable gating
    en = 1'b0; din = 8'h51; lin = 1'b0; sel = 3'd1; vin = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t5_blocked_ready", 64'(rdy), 64'h0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    send(8'h51, 1'b0, 3'd1, 1);
    en = 1'b0;
    send(8'h52, 1'b0, 3'd1, 1);
    send(8'h53, 1'b1, 3'd1, 1);
    din = 8'h54; lin = 1'b1; sel = 3'd6; vin = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t5_next_waits", 64'(rdy), 64'h0);
      chk("t5_idle", 64'(busy), 64'h0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    send(8'h54, 1'b1, 3'd6, 6);

    // 4: drops on the 6-channel instance
    @(posedge clk); #1;
    vin6 = 1'b1; sel6 = 3'd7; lin6 = 1'b0; din6 = 8'hD1;
    @(negedge clk);
    chk("t4_ready_b1", 64'(rdy6), 64'h1);
    @(posedge clk); #1;
    chk("t4_err_pulse", 64'(err6), 64'h1);
    chk("t4_cnt_1", 64'(cnt6), 64'h1);
    chk("t4_busy_drop", 64'(busy6), 64'h1);
    lin6 = 1'b1; din6 = 8'hD2;
    @(negedge clk);
    chk("t4_ready_b2", 64'(rdy6), 64'h1);
    chk("t4_no_valid", 64'(vout6), 64'h0);
    @(posedge clk); #1;
    vin6 = 1'b0;
    chk("t4_err_once", 64'(err6), 64'h0);
    chk("t4_cnt_still_1", 64'(cnt6), 64'h1);
    chk("t4_idle", 64'(busy6), 64'h0);
    chk("t4_no_valid_end", 64'(vout6), 64'h0);
    // single-beat drops at Select == N, pushing the counter past its top
    sel6 = 3'd6; lin6 = 1'b1; vin6 = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("t4_saturated", 64'(cnt6), 64'hFF);
    chk("t4_err_while_sat", 64'(err6), 64'h1);
    vin6 = 1'b0;
    @(posedge clk); #1;
    chk("t4_cnt_held", 64'(cnt6), 64'hFF);
    // highest legal channel still routes
    vin6 = 1'b1; sel6 = 3'd5; lin6 = 1'b1; din6 = 8'hE5;
    @(negedge clk);
    chk("t4_ch5_ready", 64'(rdy6), 64'h1);
    @(posedge clk); #1;
    vin6 = 1'b0;
    chk("t4_ch5_valid", 64'(vout6), 64'h20);
    chk("t4_ch5_data", 64'(dout6[47:40]), 64'hE5);
    chk("t4_ch5_last", 64'(lout6), 64'h20);

    // 6: reset mid-packet with full slots
    rin = 8'hFC;
    send(8'h61, 1'b1, 3'd0, 0);
    send(8'h62, 1'b1, 3'd1, 1);
    send(8'h63, 1'b0, 3'd4, 4);
    chk("t6_full_slots", 64'(vout), 64'h13);
    chk("t6_busy", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) sb[c].delete();
    chk("t6_vout_clear", 64'(vout), 64'h0);
    chk("t6_lout_clear", 64'(lout), 64'h0);
    chk("t6_dout_clear", dout, 64'h0);
    chk("t6_busy_clear", 64'(busy), 64'h0);
    chk("t6_cnt6_clear", 64'(cnt6), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rin = '1;
    @(posedge clk); #1;
    chk("t6_vout_after", 64'(vout), 64'h0);
    send(8'h64, 1'b0, 3'd4, 4);
    send(8'h65, 1'b1, 3'd4, 4);
    send(8'h66, 1'b1, 3'd0, 0);

    repeat (4) @(posedge clk);
    #1;
    pending = 0;
    for (int c = 0; c < 8; c++) pending += sb[c].size();
    chk("sb_drained", 64'(pending), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
